fetch_unit: RTL and testbench

Instruction-fetch stage and Fetch-Decode pipeline register of the 16-bit pipelined CPU. It generates the program counter and fetches instructions over a single-outstanding request/ready instruction-memory port. It presents the fetched instruction and its PC to Decode. It consumes the `nop` (stall) and `flush` (redirect) controls produced by the hazard detection unit downstream of it in Decode.

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register, 1-entry skid buffer and redirect drop handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  nop,
   input  logic [1:0]  flush,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr_decode,
   output logic [15:0] pc_decode,
   output logic        valid_decode
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] pend_q, pend_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pc_q, skid_pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pcd_q, pcd_d;
   logic        vld_q, vld_d;
   logic        stall, redirect;
   logic        unused_bits;

   assign stall       = nop[0];
   assign redirect    = flush[0];
   assign unused_bits = nop[1] ^ flush[1];

   // No request is ever presented while reset is held, so a response during reset is never taken.
   assign imem_req     = ~rst & (state_q != S_HOLD);
   assign imem_addr    = (state_q == S_DROP) ? pend_q : pc_q;
   assign instr_decode = instr_q;
   assign pc_decode    = pcd_q;
   assign valid_decode = vld_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      instr_d      = instr_q;
      pcd_d        = pcd_q;
      vld_d        = vld_q;
      if (redirect) begin
         instr_d = NOP_INSTR;
         pcd_d   = 16'h0000;
         vld_d   = 1'b0;
         pc_d    = branch_target;
         case (state_q)
            S_REQ: begin
               if (imem_ready) begin
                  state_d = S_REQ;
               end else begin
                  // The old address must stay on the bus until memory accepts it.
                  state_d = S_DROP;
                  pend_d  = pc_q;
               end
            end
            S_HOLD:  state_d = S_REQ;
            default: state_d = imem_ready ? S_REQ : S_DROP;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_ready) begin
                  pc_d = pc_q + 16'd1;
                  if (stall) begin
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = pc_q;
                     state_d      = S_HOLD;
                  end else begin
                     instr_d = imem_rdata;
                     pcd_d   = pc_q;
                     vld_d   = 1'b1;
                  end
               end else if (!stall) begin
                  instr_d = NOP_INSTR;
                  vld_d   = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  instr_d = skid_instr_q;
                  pcd_d   = skid_pc_q;
                  vld_d   = 1'b1;
                  state_d = S_REQ;
               end
            end
            default: begin
               instr_d = NOP_INSTR;
               vld_d   = 1'b0;
               if (imem_ready) begin
                  state_d = S_REQ;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         pend_q       <= RESET_PC;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= 16'h0000;
         instr_q      <= NOP_INSTR;
         pcd_q        <= 16'h0000;
         vld_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_q       <= pend_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         instr_q      <= instr_d;
         pcd_q        <= pcd_d;
         vld_q        <= vld_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall && !redirect && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (redirect && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/skid, redirects, drop, flush priority, wrap and reset.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [1:0]  nop, flush;
   logic [15:0] branch_target;
   logic        imem_ready;
   logic        imem_req, w_req;
   logic [15:0] imem_addr, imem_rdata, w_addr, w_rdata;
   logic [15:0] instr_decode, pc_decode, w_instr, w_pc;
   logic        valid_decode, w_valid;
   int          n_cmp = 0;
   int          n_err = 0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count, w_stall, w_flush;
`endif

   // Memory returns addr + 0x1000 so every word identifies its own address.
   assign imem_rdata = imem_addr + 16'h1000;
   assign w_rdata    = w_addr + 16'h1000;

   fetch_unit dut (
      .clk(clk), .rst(rst), .nop(nop), .flush(flush), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr_decode(instr_decode), .pc_decode(pc_decode), .valid_decode(valid_decode)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
      .clk(clk), .rst(rst), .nop(nop), .flush(flush), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_rdata(w_rdata),
      .instr_decode(w_instr), .pc_decode(w_pc), .valid_decode(w_valid)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cycles(w_stall), .flush_count(w_flush)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [15:0] i, input logic [15:0] p, input logic v);
      check({tag, ".instr"}, {16'h0, instr_decode}, {16'h0, i});
      check({tag, ".pc"},    {16'h0, pc_decode},    {16'h0, p});
      check({tag, ".valid"}, {31'h0, valid_decode}, {31'h0, v});
   endtask

   task automatic chk_reset(input string tag);
      chk_ifid(tag, 16'h0000, 16'h0000, 1'b0);
      check({tag, ".req"},  {31'h0, imem_req},  32'h0);
      check({tag, ".addr"}, {16'h0, imem_addr}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; nop = 2'b00; flush = 2'b00; branch_target = 16'h0000; imem_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      check("wrap_rst_addr", {16'h0, w_addr}, 32'h0000_FFFF);

      rst = 1'b0; imem_ready = 1'b1;
      #1;
      check("first_req", {31'h0, imem_req}, 32'h1);
      check("first_addr", {16'h0, imem_addr}, 32'h0);
      @(negedge clk);
      chk_ifid("fetch0", 16'h1000, 16'h0000, 1'b1);
      check("wrap_pc", {16'h0, w_pc}, 32'h0000_FFFF);
      check("wrap_instr", {16'h0, w_instr}, 32'h0000_0FFF);
      check("wrap_addr", {16'h0, w_addr}, 32'h0);
      @(negedge clk);
      chk_ifid("fetch1", 16'h1001, 16'h0001, 1'b1);
      @(negedge clk);
      chk_ifid("fetch2", 16'h1002, 16'h0002, 1'b1);
      check("addr3", {16'h0, imem_addr}, 32'h3);

      // Stall for three cycles while memory is ready
      nop = 2'b01;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_ifid("stall_hold", 16'h1002, 16'h0002, 1'b1);
         check("stall_req", {31'h0, imem_req}, 32'h0);
      end
      nop = 2'b00;
      @(negedge clk);
      chk_ifid("skid_out", 16'h1003, 16'h0003, 1'b1);
      check("skid_req", {31'h0, imem_req}, 32'h1);
      check("skid_addr", {16'h0, imem_addr}, 32'h4);
      @(negedge clk);
      chk_ifid("after_skid", 16'h1004, 16'h0004, 1'b1);

      // Redirect while memory is ready
      flush = 2'b01; branch_target = 16'h0040;
      @(negedge clk);
      flush = 2'b00;
      chk_ifid("flush_bubble", 16'h0000, 16'h0000, 1'b0);
      check("flush_addr", {16'h0, imem_addr}, 32'h40);
      @(negedge clk);
      chk_ifid("target", 16'h1040, 16'h0040, 1'b1);

      // Redirect with request pending: old address held, response dropped
      imem_ready = 1'b0; flush = 2'b01; branch_target = 16'h0080;
      @(negedge clk);
      flush = 2'b00;
      check("drop_addr0", {16'h0, imem_addr}, 32'h41);
      check("drop_req0", {31'h0, imem_req}, 32'h1);
      check("drop_valid0", {31'h0, valid_decode}, 32'h0);
      @(negedge clk);
      check("drop_addr1", {16'h0, imem_addr}, 32'h41);
      check("drop_instr1", {16'h0, instr_decode}, 32'h0);
      imem_ready = 1'b1;
      @(negedge clk);
      check("drop_done_addr", {16'h0, imem_addr}, 32'h80);
      chk_ifid("drop_discard", 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      chk_ifid("drop_target", 16'h1080, 16'h0080, 1'b1);

      // Stall and flush together: redirect wins, no HOLD
      nop = 2'b01; flush = 2'b01; branch_target = 16'h00C0;
      @(negedge clk);
      nop = 2'b00; flush = 2'b00;
      check("both_valid", {31'h0, valid_decode}, 32'h0);
      check("both_req", {31'h0, imem_req}, 32'h1);
      check("both_addr", {16'h0, imem_addr}, 32'hC0);
      @(negedge clk);
      chk_ifid("both_target", 16'h10C0, 16'h00C0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      check("stall_cycles", stall_cycles, 32'd3);
      check("flush_count", flush_count, 32'd3);
`endif

      // Reset during an outstanding request
      imem_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk_reset("mid_reset");
`ifdef FETCH_PERF_CNT_EN
      check("cnt_reset", stall_cycles | flush_count, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
